// File: rtl/draw_symbol_gen.sv
// ---------------------------------------------------------------------------
// draw_symbol_gen
//   Symbol plotter for the VGA drawing path. A start pulse latches an origin,
//   colour and mode. The block then emits one pixel per cycle for an X-cross,
//   box outline, filled square or erase square of side SIZE.
//
// Ports
//   clk         single clock, rising edge
//   reset       synchronous, active-high
//   start       request, sampled only in IDLE
//   mode        00 X-cross, 01 box outline, 10 fill, 11 erase (fill, colour 0)
//   x, y        symbol origin (top-left), latched on start
//   colour      draw colour, latched on start
//   hold        stalls sequencing while drawing
//   xout, yout  registered pixel coordinates (wrap modulo 2^W, no clipping)
//   colour_out  registered pixel colour
//   plot        pixel valid strobe
//   busy        high while a symbol is in progress
//   done        one-cycle pulse after the last pixel
// ---------------------------------------------------------------------------
module draw_symbol_gen #(
   parameter int SIZE     = 16,
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int COLOUR_W = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [1:0]          mode,
   input  logic [X_W-1:0]      x,
   input  logic [Y_W-1:0]      y,
   input  logic [COLOUR_W-1:0] colour,
   input  logic                hold,
   output logic [X_W-1:0]      xout,
   output logic [Y_W-1:0]      yout,
   output logic [COLOUR_W-1:0] colour_out,
   output logic                plot,
   output logic                busy,
   output logic                done
);

   localparam int KW = $clog2(SIZE*SIZE+1);

   localparam logic [KW-1:0] SZ     = KW'(SIZE);
   localparam logic [KW-1:0] M1     = KW'(SIZE-1);
   localparam logic [KW-1:0] M2     = KW'(2*(SIZE-1));
   localparam logic [KW-1:0] M3     = KW'(3*(SIZE-1));
   localparam logic [KW-1:0] M4     = KW'(4*(SIZE-1));
   localparam logic [KW-1:0] LAST_X = KW'(2*SIZE-1);
   localparam logic [KW-1:0] LAST_B = KW'(4*(SIZE-1)-1);
   localparam logic [KW-1:0] LAST_F = KW'(SIZE*SIZE-1);

   localparam logic [1:0] MODE_X     = 2'b00;
   localparam logic [1:0] MODE_BOX   = 2'b01;
   localparam logic [1:0] MODE_ERASE = 2'b11;

   typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

   state_t                state_q;
   logic [KW-1:0]         k_q;
   // Column/row of pixel k for fill/erase, kept as counters to avoid a divider.
   logic [KW-1:0]         col_q, row_q;
   logic [1:0]            mode_q;
   logic [X_W-1:0]        x0_q;
   logic [Y_W-1:0]        y0_q;
   logic [COLOUR_W-1:0]   col0_q;
   logic [X_W-1:0]        xout_q;
   logic [Y_W-1:0]        yout_q;
   logic [COLOUR_W-1:0]   cout_q;
   logic                  plot_q, busy_q, done_q;

   logic [KW-1:0]         dx_d, dy_d;
   logic                  last_d;

   // Offset of pixel k_q within the symbol, and whether it is the final one.
   always_comb begin
      dx_d   = '0;
      dy_d   = '0;
      last_d = 1'b0;
      case (mode_q)
         MODE_X: begin
            last_d = (k_q == LAST_X);
            if (k_q < SZ) begin
               dx_d = k_q;
               dy_d = k_q;
            end else begin
               // Anti-diagonal: (SIZE-1-j, j) with j = k-SIZE.
               dx_d = LAST_X - k_q;
               dy_d = k_q - SZ;
            end
         end
         MODE_BOX: begin
            last_d = (k_q == LAST_B);
            if (k_q < M1) begin
               dx_d = k_q;
               dy_d = '0;
            end else if (k_q < M2) begin
               dx_d = M1;
               dy_d = k_q - M1;
            end else if (k_q < M3) begin
               dx_d = M3 - k_q;
               dy_d = M1;
            end else begin
               dx_d = '0;
               dy_d = M4 - k_q;
            end
         end
         default: begin
            last_d = (k_q == LAST_F);
            dx_d   = col_q;
            dy_d   = row_q;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         k_q     <= '0;
         col_q   <= '0;
         row_q   <= '0;
         mode_q  <= '0;
         x0_q    <= '0;
         y0_q    <= '0;
         col0_q  <= '0;
         xout_q  <= '0;
         yout_q  <= '0;
         cout_q  <= '0;
         plot_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         plot_q <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  mode_q  <= mode;
                  x0_q    <= x;
                  y0_q    <= y;
                  col0_q  <= colour;
                  // Pixel 0 is always at the origin, so issue it straight
                  // from the inputs; sequencing continues from k=1.
                  xout_q  <= x;
                  yout_q  <= y;
                  cout_q  <= (mode == MODE_ERASE) ? '0 : colour;
                  plot_q  <= 1'b1;
                  busy_q  <= 1'b1;
                  k_q     <= KW'(1);
                  col_q   <= KW'(1);
                  row_q   <= '0;
                  state_q <= DRAW;
               end
            end
            DRAW: begin
               if (!hold) begin
                  xout_q <= x0_q + X_W'(dx_d);
                  yout_q <= y0_q + Y_W'(dy_d);
                  cout_q <= (mode_q == MODE_ERASE) ? '0 : col0_q;
                  plot_q <= 1'b1;
                  k_q    <= k_q + KW'(1);
                  if (col_q == M1) begin
                     col_q <= '0;
                     row_q <= row_q + KW'(1);
                  end else begin
                     col_q <= col_q + KW'(1);
                  end
                  // DONE covers the cycle in which the last pixel is shown;
                  // done then pulses while the FSM is already back in IDLE,
                  // so a new start can be taken in that same cycle.
                  if (last_d) state_q <= DONE;
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign xout       = xout_q;
   assign yout       = yout_q;
   assign colour_out = cout_q;
   assign plot       = plot_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_draw_symbol_gen.sv
// Scoreboard bench for draw_symbol_gen: a SIZE=4 and a SIZE=16 instance
// share the data inputs and have separate start strobes.
module tb_draw_symbol_gen;
   logic       clk = 1'b0, reset = 1'b1, start4 = 1'b0, start16 = 1'b0, hold = 1'b0;
   logic [1:0] mode = '0;
   logic [7:0] x = '0;
   logic [6:0] y = '0;
   logic [2:0] colour = '0;

   logic [7:0] xo4, xo16;
   logic [6:0] yo4, yo16;
   logic [2:0] co4, co16;
   logic       pl4, pl16, bz4, bz16, dn4, dn16;

   int cyc = 0, n_chk = 0, n_fail = 0;

   typedef struct {int x; int y; int c; int cy;} px_t;
   px_t q4[$], q16[$];
   int  d4[$], d16[$];

   // Hand-derived offsets for SIZE=4.
   int cx[8]  = '{0, 1, 2, 3, 3, 2, 1, 0};
   int cy[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
   int bx[12] = '{0, 1, 2, 3, 3, 3, 3, 2, 1, 0, 0, 0};
   int by[12] = '{0, 0, 0, 0, 1, 2, 3, 3, 3, 3, 2, 1};

   draw_symbol_gen #(.SIZE(4), .X_W(8), .Y_W(7), .COLOUR_W(3)) u4 (
      .clk(clk), .reset(reset), .start(start4), .mode(mode), .x(x), .y(y),
      .colour(colour), .hold(hold), .xout(xo4), .yout(yo4), .colour_out(co4),
      .plot(pl4), .busy(bz4), .done(dn4));

   draw_symbol_gen #(.SIZE(16), .X_W(8), .Y_W(7), .COLOUR_W(3)) u16 (
      .clk(clk), .reset(reset), .start(start16), .mode(mode), .x(x), .y(y),
      .colour(colour), .hold(hold), .xout(xo16), .yout(yo16), .colour_out(co16),
      .plot(pl16), .busy(bz16), .done(dn16));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   task automatic push_px(input bit big, input int px, input int py, input int pc, input int pcy);
      px_t e;
      e.x = px % 256; e.y = py % 128; e.c = pc; e.cy = pcy;
      if (big) q16.push_back(e); else q4.push_back(e);
   endtask

   task automatic push_fill(input bit big, input int t, input int x0, input int y0,
                            input int c, input int npix, input int sz, input bit full);
      for (int k = 0; k < npix; k++)
         push_px(big, x0 + k % sz, y0 + k / sz, c, t + 1 + k);
      if (full) begin
         if (big) d16.push_back(t + sz*sz + 1); else d4.push_back(t + sz*sz + 1);
      end
   endtask

   task automatic go(input bit big, input logic [1:0] m, input int xx, input int yy, input int cc);
      mode = m; x = 8'(xx); y = 7'(yy); colour = 3'(cc);
      if (big) start16 = 1'b1; else start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0; start16 = 1'b0;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Monitors: pop and compare whenever a DUT presents a pixel or done.
   always @(negedge clk) begin
      px_t e;
      int  dc;
      if (pl4) begin
         if (q4.size() == 0) chk("u4 unexpected plot", 1, 0);
         else begin
            e = q4.pop_front();
            chk("u4 xout", xo4, e.x);
            chk("u4 yout", yo4, e.y);
            chk("u4 colour_out", co4, e.c);
            chk("u4 pixel cycle", cyc, e.cy);
            chk("u4 busy while plot", bz4, 1);
         end
      end
      if (dn4) begin
         if (d4.size() == 0) chk("u4 unexpected done", 1, 0);
         else begin
            dc = d4.pop_front();
            chk("u4 done cycle", cyc, dc);
            chk("u4 busy at done", bz4, 0);
         end
      end
      if (pl16) begin
         if (q16.size() == 0) chk("u16 unexpected plot", 1, 0);
         else begin
            e = q16.pop_front();
            chk("u16 xout", xo16, e.x);
            chk("u16 yout", yo16, e.y);
            chk("u16 colour_out", co16, e.c);
            chk("u16 pixel cycle", cyc, e.cy);
         end
      end
      if (dn16) begin
         if (d16.size() == 0) chk("u16 unexpected done", 1, 0);
         else begin
            dc = d16.pop_front();
            chk("u16 done cycle", cyc, dc);
            chk("u16 busy at done", bz16, 0);
         end
      end
   end

   initial begin
      int t;
      repeat (3) @(negedge clk);
      chk("reset xout", xo4, 0);
      chk("reset yout", yo4, 0);
      chk("reset colour_out", co4, 0);
      chk("reset plot", pl4, 0);
      chk("reset busy", bz4, 0);
      chk("reset done", dn4, 0);
      reset = 1'b0;
      @(negedge clk);

      // X-cross SIZE=4 at (10,20) colour 5
      t = cyc;
      for (int i = 0; i < 8; i++) push_px(0, 10 + cx[i], 20 + cy[i], 5, t + 1 + i);
      d4.push_back(t + 9);
      go(0, 2'b00, 10, 20, 5);
      chk("cross busy T+1", bz4, 1);
      wait_until(t + 8);
      chk("cross busy T+8", bz4, 1);
      wait_until(t + 9);
      chk("cross plot T+9", pl4, 0);
      wait_until(t + 10);

      // Box outline at (0,0) colour 2
      t = cyc;
      for (int i = 0; i < 12; i++) push_px(0, bx[i], by[i], 2, t + 1 + i);
      d4.push_back(t + 13);
      go(0, 2'b01, 0, 0, 2);
      wait_until(t + 13);

      // Fill at (254,126) colour 7, started in the done cycle (back-to-back)
      t = cyc;
      push_fill(0, t, 254, 126, 7, 16, 4, 1);
      go(0, 2'b10, 254, 126, 7);
      wait_until(t + 20);

      // X-cross with hold sampled at the edges ending T+3 and T+4
      t = cyc;
      for (int i = 0; i < 8; i++)
         push_px(0, 50 + cx[i], 60 + cy[i], 4, (i < 3) ? t + 1 + i : t + 3 + i);
      d4.push_back(t + 11);
      go(0, 2'b00, 50, 60, 4);
      wait_until(t + 3);
      hold = 1'b1;
      wait_until(t + 4);
      chk("hold plot T+4", pl4, 0);
      wait_until(t + 5);
      chk("hold plot T+5", pl4, 0);
      chk("hold busy T+5", bz4, 1);
      hold = 1'b0;
      wait_until(t + 13);

      // Erase SIZE=16 at (100,50), colour 6 forced to 0; extra start ignored
      t = cyc;
      push_fill(1, t, 100, 50, 0, 256, 16, 1);
      go(1, 2'b11, 100, 50, 6);
      wait_until(t + 50);
      mode = 2'b00; colour = 3'd1; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      wait_until(t + 257);
      chk("erase busy at done", bz16, 0);
      wait_until(t + 262);

      // Reset while pixel 5 of a fill is on the outputs
      t = cyc;
      push_fill(0, t, 40, 30, 3, 6, 4, 0);
      go(0, 2'b10, 40, 30, 3);
      wait_until(t + 6);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid reset xout", xo4, 0);
      chk("mid reset yout", yo4, 0);
      chk("mid reset colour_out", co4, 0);
      chk("mid reset plot", pl4, 0);
      chk("mid reset busy", bz4, 0);
      chk("mid reset done", dn4, 0);
      repeat (4) @(negedge clk);

      // Fresh start after reset begins at k=0
      t = cyc;
      push_fill(0, t, 3, 4, 1, 16, 4, 1);
      go(0, 2'b10, 3, 4, 1);
      wait_until(t + 20);

      chk("u4 pixels outstanding", q4.size(), 0);
      chk("u4 done outstanding", d4.size(), 0);
      chk("u16 pixels outstanding", q16.size(), 0);
      chk("u16 done outstanding", d16.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
